// File: rtl/add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
// Contents:
//   ST_IDLE/ST_RUN/ST_DONE : FSM state encodings
//   MODE_ADD/MODE_SUB      : values of the sub input
//   state_e                : FSM state type built on the encodings above
//   maj3()                 : 3-input majority (full-adder carry)
package add_sub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/add_sub_bit_cell.sv
// One-bit full adder with an XOR on b so the same cell serves add and subtract.
// Ports:
//   a, b  : operand bits
//   sub   : 1 inverts b (two's-complement subtract with the carry seeded by the caller)
//   cIn   : carry in
//   s     : sum bit
//   cOut  : carry out
module add_sub_bit_cell
  import add_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic sub,
  input  logic cIn,
  output logic s,
  output logic cOut
);

  logic bb;

  assign bb   = b ^ sub;
  assign s    = a ^ bb ^ cIn;
  assign cOut = maj3(a, bb, cIn);

endmodule

// File: rtl/serial_adder_subtractor.sv
// Bit-serial WIDTH-bit adder/subtractor, one bit per clock, LSB first.
// Operands are captured on start; the result is held until the next accepted start.
//
// Build option: define SERIAL_ADD_SUB_OVF_EN to compile in signed-overflow
// detection; otherwise ovf is tied to 0. The port list is the same either way.
//
// Ports (vectors are [0:WIDTH-1], index 0 = MSB):
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   start  : request, honoured in IDLE or DONE
//   sub    : 0 add, 1 subtract
//   a, b   : operands
//   cIn    : carry-in (add) / borrow-in (subtract)
//   busy   : high while bits are being processed
//   done   : one-cycle pulse when s/cOut/ovf become valid
//   s      : result
//   cOut   : carry out (add) / not-borrow (subtract)
//   ovf    : signed overflow
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | processing bit WIDTH-1-count each cycle
// DONE   | result valid, done pulse; start here chains the next operation
module serial_adder_subtractor
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  input  logic             cIn,
  output logic             busy,
  output logic             done,
  output logic [0:WIDTH-1] s,
  output logic             cOut,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [0:WIDTH-1] a_q, a_d;
  logic [0:WIDTH-1] b_q, b_d;
  logic [0:WIDTH-1] s_q, s_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] bit_idx;
  logic             cell_s, cell_cout;

  // Counter runs up, so the LSB (highest index) is visited first.
  assign bit_idx = LAST - count_q;

  add_sub_bit_cell u_cell (
    .a    (a_q[bit_idx]),
    .b    (b_q[bit_idx]),
    .sub  (sub_q),
    .cIn  (carry_q),
    .s    (cell_s),
    .cOut (cell_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    count_d = count_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          // Subtract is a + ~b + 1 - cIn, i.e. carry seeded with ~cIn.
          carry_d = (sub == MODE_SUB) ? ~cIn : cIn;
          count_d = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        s_d[bit_idx] = cell_s;
        carry_d      = cell_cout;
        if (count_q == LAST) begin
          cout_d  = cell_cout;
          state_d = S_DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

`ifdef SERIAL_ADD_SUB_OVF_EN
  logic ovf_q, ovf_d;

  // On the MSB step carry_q is the carry into the MSB and cell_cout the carry out.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_RUN && count_q == LAST) begin
      ovf_d = carry_q ^ cell_cout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cOut = cout_q;

endmodule

// File: tb/tb_serial_adder_subtractor.sv
module tb_serial_adder_subtractor;

  localparam int W = 4;

`ifdef SERIAL_ADD_SUB_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic         cIn;
  logic [0:W-1] a;
  logic [0:W-1] b;
  logic         busy;
  logic         done;
  logic [0:W-1] s;
  logic         cOut;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  serial_adder_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cIn   (cIn),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cOut  (cOut),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until done is seen, starting from n0; 99 on timeout.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (done === 1'b1) return;
    end
    n = 99;
  endtask

  task automatic load(input logic [3:0] av, input logic [3:0] bv, input logic ci, input logic sb);
    a   = av;
    b   = bv;
    cIn = ci;
    sub = sb;
  endtask

  task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                        input logic ci, input logic sb,
                        input logic [3:0] es, input logic ec, input logic eo);
    int n;
    load(av, bv, ci, sb);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".busy"}, busy, 1);
    wait_done(1, n);
    check({tag, ".latency"}, n, 5);
    check({tag, ".s"}, s, es);
    check({tag, ".cOut"}, cOut, ec);
    check({tag, ".ovf"}, ovf, eo);
    check({tag, ".busy_done"}, busy, 0);
    tick();
    check({tag, ".done_pulse"}, done, 0);
  endtask

  initial begin
    int n;
    int done_seen;
    rst   = 1'b1;
    start = 1'b0;
    load(4'b0000, 4'b0000, 1'b0, 1'b0);
    #12;
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.s", s, 0);
    check("reset.cOut", cOut, 0);
    check("reset.ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_op("add",      4'b0011, 4'b0010, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b0);
    run_op("add_cy",   4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0);
    run_op("sub",      4'b0110, 4'b0101, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b0);
    run_op("sub_bor",  4'b0010, 4'b0101, 1'b0, 1'b1, 4'b1101, 1'b0, 1'b0);
    run_op("sub_bin",  4'b0101, 4'b0011, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b0);
    run_op("add_ovf",  4'b0111, 4'b0001, 1'b0, 1'b0, 4'b1000, 1'b0, OVF_ON);
    run_op("sub_ovf",  4'b1000, 4'b0001, 1'b0, 1'b1, 4'b0111, 1'b1, OVF_ON);
    run_op("add_clr",  4'b0001, 4'b0001, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0);

    // start pulsed mid-RUN with different operands must be ignored
    load(4'b0011, 4'b0010, 1'b1, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    load(4'b1111, 4'b1111, 1'b1, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(4, n);
    check("midrun.latency", n, 5);
    check("midrun.s", s, 4'b0110);
    check("midrun.cOut", cOut, 0);
    tick();
    check("midrun.no_rerun", busy, 0);

    // start held through DONE chains a second operation
    load(4'b0110, 4'b0101, 1'b0, 1'b1);
    start = 1'b1;
    tick();
    load(4'b0111, 4'b0001, 1'b0, 1'b0);
    wait_done(1, n);
    check("b2b.first_latency", n, 5);
    check("b2b.first_s", s, 4'b0001);
    check("b2b.first_cOut", cOut, 1);
    wait_done(0, n);
    start = 1'b0;
    check("b2b.second_latency", n, 5);
    check("b2b.second_s", s, 4'b1000);
    check("b2b.second_ovf", ovf, OVF_ON);
    tick();
    check("b2b.done_pulse", done, 0);

    // reset two cycles into RUN
    load(4'b1111, 4'b1111, 1'b1, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    check("midrst.s", s, 0);
    check("midrst.cOut", cOut, 0);
    check("midrst.ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    check("midrst.no_done", done_seen, 0);
    run_op("post_rst", 4'b0101, 4'b0110, 1'b0, 1'b0, 4'b1011, 1'b0, OVF_ON);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
